// File: rtl/gemm_host_ctrl_if.sv
// Load and readback valid/ready streams between host and gemm_host_ctrl.
// master drives the load stream and accepts readback; slave is the controller.
interface gemm_host_ctrl_if #(
  parameter int WW = 112
);
  logic          s_valid;
  logic          s_ready;
  logic [WW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [WW-1:0] m_data;
  logic          m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/gemm_host_ctrl.sv
// Host session controller: load mem0/mem1, run GEMM, stream mem2 back.
// Define GEMM_HOST_PERF_EN to count RUN cycles on perf_cycles_o.
module gemm_host_ctrl #(
  parameter int DATA_WIDTH      = 8,
  parameter int LANES           = 14,
  parameter int MEM0_DEPTH      = 4116,
  parameter int MEM0_ADDR_WIDTH = 13,
  parameter int MEM1_DEPTH      = 1470,
  parameter int MEM1_ADDR_WIDTH = 11,
  parameter int MEM2_DEPTH      = 896,
  parameter int MEM2_ADDR_WIDTH = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  gemm_host_ctrl_if.slave bus,
  output logic mem0_ce1,
  output logic mem0_we1,
  output logic [MEM0_ADDR_WIDTH-1:0] mem0_addr1,
  output logic [DATA_WIDTH*LANES-1:0] mem0_d1,
  output logic mem1_ce1,
  output logic mem1_we1,
  output logic [MEM1_ADDR_WIDTH-1:0] mem1_addr1,
  output logic [DATA_WIDTH*LANES-1:0] mem1_d1,
  output logic gemm_start_o,
  input  logic gemm_finish_i,
  output logic mem2_ce1,
  output logic mem2_we1,
  output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr1,
  input  logic [DATA_WIDTH*LANES-1:0] mem2_q1_i,
  output logic busy_o,
  output logic done_o,
  output logic [31:0] perf_cycles_o
);

  localparam int WW = DATA_WIDTH * LANES;
  localparam int A0 = MEM0_ADDR_WIDTH;
  localparam int A1 = MEM1_ADDR_WIDTH;
  localparam int A2 = MEM2_ADDR_WIDTH;
  localparam logic [A0-1:0] LAST0 = A0'(MEM0_DEPTH - 1);
  localparam logic [A1-1:0] LAST1 = A1'(MEM1_DEPTH - 1);
  localparam logic [A2-1:0] LAST2 = A2'(MEM2_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD0, LOAD1, RUN, DUMP, DONE
  } state_t;

  state_t state_q, state_d;

  logic [A0-1:0] a0_q, a0_d;
  logic [A1-1:0] a1_q, a1_d;
  logic [A2-1:0] a2_q, a2_d;
  logic          rd_all_q, rd_all_d;

  logic          w0_q, w0_d;
  logic [A0-1:0] w0a_q, w0a_d;
  logic [WW-1:0] w0d_q, w0d_d;
  logic          w1_q, w1_d;
  logic [A1-1:0] w1a_q, w1a_d;
  logic [WW-1:0] w1d_q, w1d_d;

  logic          gs_q, gs_d;
  logic          rv_q, rv_d;
  logic          rl_q, rl_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [WW-1:0] fd_q [2];
  logic [WW-1:0] fd_d [2];
  logic [1:0]    fl_q, fl_d;

  logic       hs, pop, issue, wi;
  logic [2:0] occ;

  always_comb begin
    hs    = bus.s_valid && (state_q == LOAD0 || state_q == LOAD1);
    pop   = (cnt_q != 2'd0) && bus.m_ready;
    // Credit the word leaving this cycle so full rate fits in two entries.
    occ   = 3'(cnt_q) + 3'(rv_q) - 3'(pop);
    issue = (state_q == DUMP) && !rd_all_q && (occ < 3'd2);
  end

  always_comb begin
    state_d  = state_q;
    a0_d     = a0_q;
    a1_d     = a1_q;
    a2_d     = a2_q;
    rd_all_d = rd_all_q;
    w0_d     = 1'b0;
    w0a_d    = '0;
    w0d_d    = '0;
    w1_d     = 1'b0;
    w1a_d    = '0;
    w1d_d    = '0;
    gs_d     = (state_q == RUN) && !gemm_finish_i;
    unique case (state_q)
      IDLE: if (start_i) state_d = LOAD0;
      LOAD0: if (hs) begin
        w0_d  = 1'b1;
        w0a_d = a0_q;
        w0d_d = bus.s_data;
        if (a0_q == LAST0) begin
          a0_d    = '0;
          state_d = LOAD1;
        end else begin
          a0_d = a0_q + A0'(1);
        end
      end
      LOAD1: if (hs) begin
        w1_d  = 1'b1;
        w1a_d = a1_q;
        w1d_d = bus.s_data;
        if (a1_q == LAST1) begin
          a1_d    = '0;
          state_d = RUN;
        end else begin
          a1_d = a1_q + A1'(1);
        end
      end
      RUN: if (gemm_finish_i) state_d = DUMP;
      DUMP: begin
        if (issue) begin
          if (a2_q == LAST2) begin
            a2_d     = '0;
            rd_all_d = 1'b1;
          end else begin
            a2_d = a2_q + A2'(1);
          end
        end
        if (pop && fl_q[0]) begin
          state_d  = DONE;
          rd_all_d = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fd_d  = fd_q;
    fl_d  = fl_q;
    rv_d  = issue;
    rl_d  = issue && (a2_q == LAST2);
    cnt_d = cnt_q + 2'(rv_q) - 2'(pop);
    wi    = (cnt_q == 2'd2) || (cnt_q == 2'd1 && !pop);
    if (pop) begin
      fd_d[0] = fd_q[1];
      fl_d[0] = fl_q[1];
      fl_d[1] = 1'b0;
    end
    if (rv_q) begin
      fd_d[wi] = mem2_q1_i;
      fl_d[wi] = rl_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a0_q     <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
      rd_all_q <= 1'b0;
      w0_q     <= 1'b0;
      w0a_q    <= '0;
      w0d_q    <= '0;
      w1_q     <= 1'b0;
      w1a_q    <= '0;
      w1d_q    <= '0;
      gs_q     <= 1'b0;
      rv_q     <= 1'b0;
      rl_q     <= 1'b0;
      cnt_q    <= '0;
      fd_q[0]  <= '0;
      fd_q[1]  <= '0;
      fl_q     <= '0;
    end else begin
      state_q  <= state_d;
      a0_q     <= a0_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      rd_all_q <= rd_all_d;
      w0_q     <= w0_d;
      w0a_q    <= w0a_d;
      w0d_q    <= w0d_d;
      w1_q     <= w1_d;
      w1a_q    <= w1a_d;
      w1d_q    <= w1d_d;
      gs_q     <= gs_d;
      rv_q     <= rv_d;
      rl_q     <= rl_d;
      cnt_q    <= cnt_d;
      fd_q     <= fd_d;
      fl_q     <= fl_d;
    end
  end

`ifdef GEMM_HOST_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q != RUN && state_d == RUN) perf_d = '0;
    else if (state_q == RUN && perf_q != '1) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

  assign bus.s_ready  = (state_q == LOAD0) || (state_q == LOAD1);
  assign bus.m_valid  = (cnt_q != 2'd0);
  assign bus.m_data   = bus.m_valid ? fd_q[0] : '0;
  assign bus.m_last   = bus.m_valid && fl_q[0];
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign gemm_start_o = gs_q;
  assign mem0_ce1     = w0_q;
  assign mem0_we1     = w0_q;
  assign mem0_addr1   = w0a_q;
  assign mem0_d1      = w0d_q;
  assign mem1_ce1     = w1_q;
  assign mem1_we1     = w1_q;
  assign mem1_addr1   = w1a_q;
  assign mem1_d1      = w1d_q;
  assign mem2_ce1     = issue;
  assign mem2_we1     = 1'b0;
  assign mem2_addr1   = issue ? a2_q : '0;

endmodule

// File: doc/gemm_host_ctrl.md
# gemm_host_ctrl

Synthesizable host-side session controller for the GEMM core, replacing bench-driven BRAM loading and readback. It accepts a valid/ready word stream, fills the Ifmap BRAM (mem0) and the Weight BRAM (mem1) through their port 1, and pulses the GEMM start handshake. It then streams the whole Ofmap BRAM (mem2) back out on a backpressured valid/ready interface. Depths, lane count and element width are parametrised so one controller serves every layer configuration.

## Interface
- DATA_WIDTH, 8, element width in bits
- LANES, 14, elements per BRAM word (PE_SIZE); word width WW = DATA_WIDTH*LANES
- MEM0_DEPTH, 4116, Ifmap words to load
- MEM0_ADDR_WIDTH, 13, mem0 address width
- MEM1_DEPTH, 1470, Weight words to load
- MEM1_ADDR_WIDTH, 11, mem1 address width
- MEM2_DEPTH, 896, Ofmap words to read back
- MEM2_ADDR_WIDTH, 10, mem2 address width
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  begin session; sampled only in IDLE
- s_valid  in  1  load stream word valid
- s_ready  out  1  load stream ready
- s_data  in  WW  load word, lane 0 in MSBs
- mem0_ce1, mem0_we1  out  1 each  mem0 port-1 enable/write
- mem0_addr1  out  MEM0_ADDR_WIDTH  mem0 address
- mem0_d1  out  WW  mem0 write data
- mem1_ce1, mem1_we1  out  1 each  mem1 port-1 enable/write
- mem1_addr1  out  MEM1_ADDR_WIDTH  mem1 address
- mem1_d1  out  WW  mem1 write data
- gemm_start_o  out  1  GEMM start level
- gemm_finish_i  in  1  GEMM finish
- mem2_ce1, mem2_we1  out  1 each  mem2 port-1 enable/write (we always 0)
- mem2_addr1  out  MEM2_ADDR_WIDTH  mem2 read address
- mem2_q1_i  in  WW  mem2 read data, 1-cycle latency
- m_valid  out  1  readback word valid
- m_ready  in  1  readback ready
- m_data  out  WW  readback word
- m_last  out  1  high with final readback word
- busy_o  out  1  high in any state but IDLE
- done_o  out  1  one-cycle pulse at session end
- perf_cycles_o  out  32  GEMM run-cycle count

## Operation
- States: IDLE, LOAD0, LOAD1, RUN, DUMP, DONE.
- IDLE: start_i=1 -> LOAD0. start_i in any other state is ignored.
- LOAD0: s_ready=1. Each handshake writes s_data to mem0 at address 0,1,…,MEM0_DEPTH-1. The handshake accepting word MEM0_DEPTH-1 -> LOAD1.
- LOAD1: same for mem1, addresses 0…MEM1_DEPTH-1. The last accepted word -> RUN.
- RUN: gemm_start_o=1, s_ready=0. gemm_finish_i sampled high -> DUMP, and gemm_start_o drops. gemm_finish_i outside RUN is ignored.
- DUMP: reads mem2 addresses 0…MEM2_DEPTH-1 in order. A 2-entry output FIFO absorbs read latency. A read issues only if FIFO occupancy plus in-flight reads < 2, so no word is lost under m_ready stalls. m_last marks address MEM2_DEPTH-1. That handshake -> DONE.
- DONE: done_o=1 for one cycle -> IDLE.
- Address counters wrap to 0 on state exit. Counter widths are the respective ADDR_WIDTH. Depth must be <= 2^ADDR_WIDTH.
- All mem outputs are 0 when not writing or reading.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0; FIFO empty.
- start_i high at edge N -> busy_o and s_ready high after edge N.
- Load writes are registered. A handshake at edge t drives ce/we/addr/d high during cycle t..t+1, for exactly one cycle per word. Sustained rate is 1 word/cycle.
- gemm_start_o rises in the cycle after the final mem1 write strobe.
- First mem2_ce1 occurs the cycle after entering DUMP. First m_valid follows 2 cycles after entering DUMP. Rate is 1 word/cycle with m_ready held high.
- m_valid/m_data/m_last stay stable while m_valid=1 and m_ready=0.
- rst asserted mid-session aborts immediately to IDLE with reset values. Partial BRAM contents are left as written.

## Configuration
- GEMM_HOST_PERF_EN defined: a 32-bit counter clears on entering RUN and increments every RUN cycle, saturating at 2^32-1. perf_cycles_o holds the final count until the next RUN entry or rst.
- GEMM_HOST_PERF_EN undefined: no counter logic; perf_cycles_o tied to 0.

## Test plan
- Reset then idle: rst pulse, s_valid=1 with no start_i -> s_ready=0, no mem writes, busy_o=0.
- Full session with default params and continuous valid/ready: 5586 words in -> mem0[0..4115] and mem1[0..1469] match input, gemm_start_o rises once. A model asserts finish after 100 cycles -> 896 words out in order, m_last on word 895, done_o one pulse.
- Load bubbles: s_valid toggled pseudo-randomly -> every accepted word is written exactly once, no address skips.
- Readback backpressure: m_ready low 3 of 4 cycles -> output sequence identical to mem2 contents, no duplicates or drops, data stable while stalled.
- Reset mid-DUMP at word 400 -> all outputs 0 next cycle. A new start_i runs a full clean session.
- With GEMM_HOST_PERF_EN: finish after 100 RUN cycles -> perf_cycles_o=100. Without the macro -> perf_cycles_o=0.
